// File: rtl/div_loop_if.sv
// Start/ready handshake and result bus of the sequential restoring divider.
interface div_loop_if #(
  parameter int DW = 16,
  parameter int VW = 8
);
  logic          start;
  logic [DW-1:0] a;
  logic [VW-1:0] b;
  logic          ready;
  logic [DW-1:0] quotient;
  logic [VW-1:0] remainder;
  logic          div_by_zero;

  modport master (output start, a, b,
                  input  ready, quotient, remainder, div_by_zero);
  modport slave  (input  start, a, b,
                  output ready, quotient, remainder, div_by_zero);
endinterface

// File: rtl/div_loop.sv
// Sequential restoring divider: one quotient bit per clock, DW busy cycles,
// result held stable until the next accepted start.
module div_loop #(
  parameter int DW = 16,
  parameter int VW = 8
) (
  input  logic       clk,
  input  logic       reset,
  div_loop_if.slave  bus
);
  localparam int CW = $clog2(DW + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t        state, state_nx;
  logic [DW-1:0] sh, q_r, sh_nx;
  logic [VW-1:0] dv, r_r, p, p_nx;
  logic [VW:0]   p_sh;
  logic [CW-1:0] cnt;
  logic          zf, dbz_r, ge, accept, finish;

  // The partial remainder is always < b between steps, so only its low VW
  // bits are stored; the VW+1-bit shifted value carries the compare headroom.
  always_comb begin
    p_sh  = {p, sh[DW-1]};
    ge    = (p_sh >= {1'b0, dv});
    p_nx  = ge ? VW'(p_sh - {1'b0, dv}) : p_sh[VW-1:0];
    sh_nx = {sh[DW-2:0], ge};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    finish   = 1'b0;
    case (state)
      IDLE, DONE: if (bus.start) begin
        accept   = 1'b1;
        state_nx = BUSY;
      end
      BUSY: if (zf || cnt == CW'(1)) begin
        finish   = 1'b1;
        state_nx = DONE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sh    <= '0;
      dv    <= '0;
      p     <= '0;
      cnt   <= '0;
      zf    <= 1'b0;
      q_r   <= '0;
      r_r   <= '0;
      dbz_r <= 1'b0;
    end else begin
      if (accept) begin
        sh  <= bus.a;
        dv  <= bus.b;
        p   <= '0;
        zf  <= (bus.b == '0);
        cnt <= (bus.b == '0) ? CW'(1) : CW'(DW);
      end else if (state == BUSY && !zf) begin
        sh  <= sh_nx;
        p   <= p_nx;
        cnt <= cnt - CW'(1);
      end
      // Results land together on the BUSY->DONE edge only.
      if (finish) begin
        q_r   <= zf ? '1 : sh_nx;
        r_r   <= zf ? '0 : p_nx;
        dbz_r <= zf;
      end
    end
  end

  assign bus.ready       = (state != BUSY);
  assign bus.quotient    = q_r;
  assign bus.remainder   = r_r;
  assign bus.div_by_zero = dbz_r;
endmodule

// File: tb/tb_div_loop.sv
// Scoreboard bench for div_loop: stimulus pushes model results, a monitor
// pops and compares whenever ready rises after a busy period.
module tb_div_loop;
  localparam int DW = 16;
  localparam int VW = 8;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  div_loop_if #(.DW(DW), .VW(VW)) dif ();

  div_loop #(.DW(DW), .VW(VW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (dif.slave)
  );

  typedef struct {
    logic [DW-1:0] a;
    logic [VW-1:0] b;
    logic [DW-1:0] q;
    logic [VW-1:0] r;
    logic          dbz;
    int            lat;
  } exp_t;

  exp_t sb[$];
  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: tracks one busy period at a time, checks latency, hold and result.
  logic          busy = 1'b0;
  logic          hold_bad = 1'b0;
  int            lat = 0;
  logic [DW-1:0] last_q = '0;
  logic [VW-1:0] last_r = '0;
  logic          last_dbz = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      sb.delete();
      busy = 1'b0; lat = 0;
      last_q = '0; last_r = '0; last_dbz = 1'b0;
    end else if (!dif.ready) begin
      if (!busy) begin busy = 1'b1; lat = 0; hold_bad = 1'b0; end
      lat++;
      if (dif.quotient !== last_q || dif.remainder !== last_r || dif.div_by_zero !== last_dbz)
        hold_bad = 1'b1;
    end else if (busy) begin
      busy = 1'b0;
      if (sb.size() == 0) begin
        chk("unexpected_completion", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("quotient", 32'(dif.quotient), 32'(e.q));
        chk("remainder", 32'(dif.remainder), 32'(e.r));
        chk("div_by_zero", 32'(dif.div_by_zero), 32'(e.dbz));
        chk("busy_cycles", 32'(lat), 32'(e.lat));
        chk("held_while_busy", 32'(hold_bad), 32'd0);
        if (e.b != 0)
          chk("q*b+r==a,r<b",
              32'((int'(dif.quotient) * int'(e.b) + int'(dif.remainder) == int'(e.a))
                  && (dif.remainder < e.b)), 32'd1);
      end
      last_q = dif.quotient; last_r = dif.remainder; last_dbz = dif.div_by_zero;
    end
  end

  // Called at a negedge; returns at the negedge where ready is seen high.
  task automatic wait_ready();
    int k = 0;
    while (!dif.ready && k < 100) begin @(negedge clk); k++; end
    if (!dif.ready) chk("ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic issue(input logic [DW-1:0] av, input logic [VW-1:0] bv);
    exp_t e;
    wait_ready();
    dif.start = 1'b1; dif.a = av; dif.b = bv;
    e.a = av; e.b = bv;
    if (bv == 0) begin
      e.q = '1; e.r = '0; e.dbz = 1'b1; e.lat = 1;
    end else begin
      e.q = av / bv; e.r = VW'(av % bv); e.dbz = 1'b0; e.lat = DW;
    end
    sb.push_back(e);
    @(negedge clk);
    dif.start = 1'b0;
    dif.a = DW'($urandom); dif.b = VW'($urandom);
  endtask

  task automatic drain();
    int k = 0;
    while (sb.size() != 0 && k < 100) begin @(negedge clk); k++; end
    if (sb.size() != 0) chk("drain_timeout", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    dif.start = 1'b0; dif.a = '0; dif.b = '0;
    repeat (3) @(negedge clk);
    chk("reset_ready", 32'(dif.ready), 32'd1);
    chk("reset_q", 32'(dif.quotient), 32'd0);
    chk("reset_r", 32'(dif.remainder), 32'd0);
    chk("reset_dbz", 32'(dif.div_by_zero), 32'd0);
    reset = 1'b1;
    @(negedge clk);

    issue(16'd100, 8'd7);
    issue(16'd65535, 8'd1);
    issue(16'd5, 8'd255);
    issue(16'd255, 8'd255);
    issue(16'd1234, 8'd0);
    issue(16'd9, 8'd3);

    // start pulse mid-operation must be ignored
    issue(16'd100, 8'd7);
    repeat (3) @(negedge clk);
    dif.start = 1'b1; dif.a = 16'd50; dif.b = 8'd5;
    @(negedge clk);
    dif.start = 1'b0;
    drain();

    // reset mid-operation aborts with no partial result
    issue(16'd40000, 8'd13);
    repeat (6) @(negedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
    #1;
    chk("abort_ready", 32'(dif.ready), 32'd1);
    chk("abort_q", 32'(dif.quotient), 32'd0);
    chk("abort_r", 32'(dif.remainder), 32'd0);
    chk("abort_dbz", 32'(dif.div_by_zero), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    issue(16'd9000, 8'd77);

    for (int i = 0; i < 1000; i++)
      issue(DW'($urandom), VW'($urandom_range(1, 255)));
    wait_ready();
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
